// File: rtl/irrigation_matrix_scan_controller_pkg.sv
// Shared constants, state encoding and per-column glyph table for the irrigation status matrix.
package irrigation_matrix_scan_controller_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;

  localparam logic [1:0] STATUS_CODE_0 = 2'b00;
  localparam logic [1:0] STATUS_CODE_1 = 2'b01;
  localparam logic [1:0] STATUS_CODE_2 = 2'b10;
  localparam logic [1:0] STATUS_CODE_3 = 2'b11;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Indexed [column][status]; each entry is row6..row0.
  localparam logic [NUM_ROWS-1:0] IMAGE_TABLE [NUM_COLS][4] = '{
    '{7'b0111110, 7'b0111110, 7'b1111111, 7'b1000001},
    '{7'b1001001, 7'b1001000, 7'b1001001, 7'b0100010},
    '{7'b1001001, 7'b1001000, 7'b1001001, 7'b0011100},
    '{7'b1110111, 7'b1110110, 7'b0110110, 7'b0110110},
    '{7'b0110110, 7'b0110000, 7'b0000110, 7'b0100010}
  };

  function automatic logic [NUM_ROWS-1:0] column_image(input logic [2:0] col,
                                                        input logic [1:0] status);
    return IMAGE_TABLE[col][status];
  endfunction

endpackage

// File: rtl/irrigation_matrix_scan_controller_image.sv
// Combinational image lookup: one status decoder per column, selected by the column index.
module irrigation_status_image
  import irrigation_matrix_scan_controller_pkg::*;
(
  input  logic [2:0]          col_idx,
  input  logic [1:0]          status,
  output logic [NUM_ROWS-1:0] rows
);

  logic [NUM_ROWS-1:0] col_img [NUM_COLS];

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_dec
    assign col_img[c] = column_image(3'(c), status);
  end

  always_comb begin
    rows = '0;
    if (col_idx < 3'(NUM_COLS)) rows = col_img[col_idx];
  end

endmodule

// File: rtl/irrigation_matrix_scan_controller.sv
// Column scan FSM for the 5x7 irrigation status matrix with inter-column blanking
// and frame-synchronous status sampling.
module irrigation_matrix_scan_controller
  import irrigation_matrix_scan_controller_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit COL_ACTIVE_LOW = 1'b0,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          irrigation_status,
  output logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic                frame_done,
  output logic [1:0]          status_latched
);

  localparam int MAX_CYC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0]    LAST_COL   = 3'(NUM_COLS - 1);

  scan_state_e         state, state_nxt;
  logic [2:0]          col_idx, col_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [1:0]          status_q, status_nxt;
  logic [NUM_COLS-1:0] cols_q, cols_nxt;
  logic [NUM_ROWS-1:0] rows_q, rows_nxt, img;
  logic                fd_q, fd_nxt;

  // Lookup uses next-cycle values so a one-cycle blank can still pick up a fresh sample.
  irrigation_status_image u_image (
    .col_idx (col_nxt),
    .status  (status_nxt),
    .rows    (img)
  );

  always_comb begin
    state_nxt  = state;
    col_nxt    = col_idx;
    cnt_nxt    = cnt;
    status_nxt = status_q;
    if (!enable) begin
      state_nxt = BLANK;
      col_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      if (state == BLANK && col_idx == 3'd0 && cnt == '0) status_nxt = irrigation_status;
      unique case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            col_nxt   = (col_idx == LAST_COL) ? 3'd0 : col_idx + 3'd1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      endcase
    end
    cols_nxt = '0;
    rows_nxt = '0;
    if (state_nxt == DRIVE) begin
      cols_nxt = NUM_COLS'(1) << col_nxt;
      rows_nxt = img;
    end
    fd_nxt = (state_nxt == DRIVE) && (col_nxt == LAST_COL) && (cnt_nxt == DRIVE_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BLANK;
      col_idx  <= '0;
      cnt      <= '0;
      status_q <= STATUS_CODE_0;
      cols_q   <= '0;
      rows_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      col_idx  <= col_nxt;
      cnt      <= cnt_nxt;
      status_q <= status_nxt;
      cols_q   <= cols_nxt;
      rows_q   <= rows_nxt;
      fd_q     <= fd_nxt;
    end
  end

  assign cols           = COL_ACTIVE_LOW ? ~cols_q : cols_q;
  assign rows           = ROW_ACTIVE_LOW ? ~rows_q : rows_q;
  assign frame_done     = fd_q;
  assign status_latched = status_q;

endmodule

// File: tb/tb_irrigation_matrix_scan_controller.sv
// Bench for the matrix scan controller: three parameterisations share one stimulus stream,
// a timeline model feeds a scoreboard queue, plus spot tables and corner sequences.
module tb_irrigation_matrix_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic [1:0] status;
  logic [6:0] rows_a, rows_b, rows_c;
  logic [4:0] cols_a, cols_b, cols_c;
  logic       fd_a, fd_b, fd_c;
  logic [1:0] st_a, st_b, st_c;

  irrigation_matrix_scan_controller #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clock(clk), .reset(reset), .enable(enable), .irrigation_status(status),
    .rows(rows_a), .cols(cols_a), .frame_done(fd_a), .status_latched(st_a));

  irrigation_matrix_scan_controller #(.SCAN_DIV(4), .BLANK_CYCLES(2),
                                      .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b1)) dut_b (
    .clock(clk), .reset(reset), .enable(enable), .irrigation_status(status),
    .rows(rows_b), .cols(cols_b), .frame_done(fd_b), .status_latched(st_b));

  irrigation_matrix_scan_controller #(.SCAN_DIV(1), .BLANK_CYCLES(1)) dut_c (
    .clock(clk), .reset(reset), .enable(enable), .irrigation_status(status),
    .rows(rows_c), .cols(cols_c), .frame_done(fd_c), .status_latched(st_c));

  typedef struct {
    logic [4:0] c;
    logic [6:0] r;
    logic       rv;
    logic       fd;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [4:0] cols;
    logic       fd;
  } vec_t;

  exp_t       sb[$];
  int         nvec = 0;
  int         nerr = 0;
  int         t = 0;
  logic [1:0] lat_ab = 2'b00;
  logic [1:0] lat_c  = 2'b00;

  function automatic logic [6:0] img3(input logic [1:0] s);
    case (s)
      2'b00:   return 7'b1110111;
      2'b01:   return 7'b1110110;
      default: return 7'b0110110;
    endcase
  endfunction

  // Expected outputs at cycle tt of a scan that started (blank, column 0) at tt=0.
  function automatic exp_t model(input int tt, input int s, input int b, input logic inv,
                                 input logic [1:0] st);
    exp_t e;
    int   per = 5 * (s + b);
    int   pos = tt % per;
    int   col = pos / (s + b);
    logic act = (pos % (s + b)) >= b;
    e.c  = act ? 5'(1 << col) : 5'b0;
    e.r  = act ? img3(st) : 7'b0;
    e.rv = !act || (col == 3);
    e.fd = (pos == per - 1);
    e.st = st;
    if (inv) begin
      e.c = ~e.c;
      e.r = ~e.r;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [4:0] c, input logic [6:0] r,
                     input logic fd, input logic [1:0] st);
    chk({tag, "_cols"}, 32'(c), 32'(e.c));
    if (e.rv) chk({tag, "_rows"}, 32'(r), 32'(e.r));
    chk({tag, "_frame_done"}, 32'(fd), 32'(e.fd));
    chk({tag, "_status"}, 32'(st), 32'(e.st));
  endtask

  // Advance one clock with the currently driven inputs; expectations queued before the edge.
  task automatic tick();
    exp_t ea, eb, ec;
    if (reset) begin
      t = 0;
      lat_ab = 2'b00;
      lat_c  = 2'b00;
    end else if (!enable) begin
      t = 0;
    end else begin
      if (t % 30 == 0) lat_ab = status;
      if (t % 10 == 0) lat_c = status;
      t++;
    end
    sb.push_back(model(t, 4, 2, 1'b0, lat_ab));
    sb.push_back(model(t, 4, 2, 1'b1, lat_ab));
    sb.push_back(model(t, 1, 1, 1'b0, lat_c));
    @(posedge clk);
    #1;
    if (sb.size() < 3) begin
      chk("scoreboard_depth", 32'(sb.size()), 32'd3);
    end else begin
      ea = sb.pop_front();
      eb = sb.pop_front();
      ec = sb.pop_front();
      cmp("a", ea, cols_a, rows_a, fd_a, st_a);
      cmp("b", eb, cols_b, rows_b, fd_b, st_b);
      cmp("c", ec, cols_c, rows_c, fd_c, st_c);
    end
  endtask

  task automatic run_to(input int n);
    int g = 0;
    while (t != n && g < 500) begin
      tick();
      g++;
    end
    chk("reach_cycle", 32'(t), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[14];
    int   pulses;
    tab = '{
      '{0,  5'b00000, 1'b0}, '{1,  5'b00000, 1'b0}, '{2,  5'b00001, 1'b0},
      '{5,  5'b00001, 1'b0}, '{6,  5'b00000, 1'b0}, '{7,  5'b00000, 1'b0},
      '{8,  5'b00010, 1'b0}, '{20, 5'b01000, 1'b0}, '{26, 5'b10000, 1'b0},
      '{28, 5'b10000, 1'b0}, '{29, 5'b10000, 1'b1}, '{30, 5'b00000, 1'b0},
      '{32, 5'b00001, 1'b0}, '{59, 5'b10000, 1'b1}
    };

    reset  = 1'b1;
    enable = 1'b1;
    status = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;

    // Reset state, including inactive pin levels of the inverted instance
    chk("rst_cols_a", 32'(cols_a), 32'h00);
    chk("rst_rows_a", 32'(rows_a), 32'h00);
    chk("rst_fd_a", 32'(fd_a), 32'h0);
    chk("rst_status_a", 32'(st_a), 32'h0);
    chk("rst_cols_b", 32'(cols_b), 32'h1f);
    chk("rst_rows_b", 32'(rows_b), 32'h7f);

    // Scan order, blanking and frame_done timing
    for (int i = 0; i < 14; i++) begin
      run_to(tab[i].cyc);
      chk("scan_cols", 32'(cols_a), 32'(tab[i].cols));
      chk("scan_frame_done", 32'(fd_a), 32'(tab[i].fd));
    end

    // Status only takes effect at the next frame boundary
    status = 2'b10;
    run_to(80);
    chk("c3_cols", 32'(cols_a), 32'h08);
    chk("c3_rows_10", 32'(rows_a), 32'b0110110);
    status = 2'b00;
    run_to(83);
    chk("c3_rows_hold", 32'(rows_a), 32'b0110110);
    run_to(110);
    chk("c3_rows_00", 32'(rows_a), 32'b1110111);

    // Disable during column 2 drive, then re-enable with a new status
    run_to(134);
    chk("c2_cols", 32'(cols_a), 32'h04);
    enable = 1'b0;
    tick();
    chk("off_cols", 32'(cols_a), 32'h00);
    chk("off_rows", 32'(rows_a), 32'h00);
    repeat (3) tick();
    chk("off_hold_cols", 32'(cols_a), 32'h00);
    chk("off_hold_fd", 32'(fd_a), 32'h0);
    status = 2'b11;
    enable = 1'b1;
    tick();
    chk("reen_blank", 32'(cols_a), 32'h00);
    tick();
    chk("reen_cols", 32'(cols_a), 32'h01);
    chk("reen_status", 32'(st_a), 32'h3);

    // Inverted polarity, column 3 with status 01
    status = 2'b01;
    run_to(50);
    chk("inv_cols", 32'(cols_b), 32'b10111);
    chk("inv_rows", 32'(rows_b), 32'b0001001);
    chk("inv_status", 32'(st_b), 32'h1);

    // Reset during column 4 drive
    run_to(56);
    chk("c4_cols", 32'(cols_a), 32'h10);
    reset = 1'b1;
    tick();
    chk("mrst_cols", 32'(cols_a), 32'h00);
    chk("mrst_rows", 32'(rows_a), 32'h00);
    chk("mrst_status", 32'(st_a), 32'h0);
    chk("mrst_fd", 32'(fd_a), 32'h0);
    reset = 1'b0;
    tick();
    chk("mrst_blank", 32'(cols_a), 32'h00);
    tick();
    chk("mrst_cols_on", 32'(cols_a), 32'h01);

    // Minimum timing: frame_done every 10 cycles
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fd_c) begin
        pulses++;
        chk("min_fd_cols", 32'(cols_c), 32'h10);
      end
    end
    chk("min_fd_count", 32'(pulses), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/irrigation_matrix_scan_controller.md
Name: irrigation_matrix_scan_controller

Overview:
Time-multiplexed scan controller for the 5-column x 7-row LED matrix that shows irrigation status.
- Walks the columns in order and drives each column's image from the per-column irrigation status decoders onto the shared row lines.
- Inserts a blanking gap between columns to suppress ghosting.
- Samples the 2-bit irrigation status only at frame boundaries, so a frame never shows mixed images.
- Sits between the irrigation control logic and the matrix pins at top level.

Parameters:
NUM_COLS, 5, number of matrix columns scanned (fixed at 5 for the current image set)
NUM_ROWS, 7, row lines per column
SCAN_DIV, 50000, clock cycles each column is driven (1 ms at 50 MHz); must be >= 1
BLANK_CYCLES, 500, clock cycles with all columns off before each column; must be >= 1
COL_ACTIVE_LOW, 0, 1 inverts the cols output at the pins
ROW_ACTIVE_LOW, 0, 1 inverts the rows output at the pins

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scanning; 0 = display off, scan parked
irrigation_status  input  2  current irrigation condition code (00, 01, 10, 11)
rows  output  NUM_ROWS  row drive for the active column (bit i = row i)
cols  output  NUM_COLS  one-hot column select; all-inactive during blanking
frame_done  output  1  one-cycle pulse in the last DRIVE cycle of column NUM_COLS-1
status_latched  output  2  status code currently being displayed

Behaviour:
- All outputs are registered.
- Reset: rows and cols at inactive level (0 unless the polarity parameter is set), frame_done=0, status_latched=00, FSM=BLANK, col_idx=0, cycle counter=0.
- FSM has two states, BLANK and DRIVE. Cycle counter width is clog2(max(SCAN_DIV, BLANK_CYCLES)).
- BLANK: cols and rows inactive. Counts BLANK_CYCLES cycles, then goes to DRIVE with counter cleared.
- DRIVE: cols = one-hot(col_idx). rows = image(col_idx, status_latched). Counts SCAN_DIV cycles, then goes to BLANK and col_idx increments, wrapping NUM_COLS-1 -> 0.
- Status sampling: status_latched <= irrigation_status only on the first BLANK cycle of column 0. This covers the first BLANK cycle after reset and after enable rises. Changes at any other time take effect at the next frame.
- Latency: with enable=1 held from reset release (cycle 0), cols first goes active in cycle BLANK_CYCLES. Frame period is NUM_COLS*(BLANK_CYCLES+SCAN_DIV) cycles.
- frame_done is high for exactly 1 cycle per frame: the final DRIVE cycle of column NUM_COLS-1. It is never high while enable=0.
- enable=0, sampled on any edge: the next cycle forces BLANK with col_idx=0 and counter=0, outputs inactive; the FSM holds there.
- enable rising: the scan restarts exactly as after reset, but status_latched is reloaded rather than cleared.
- Reset asserted mid-DRIVE: outputs go inactive on the next edge. Reset has priority over enable.
- Image lookup is combinational from col_idx and status_latched, and is registered together with cols so rows and cols change on the same edge.
- Column 3 image by status (row6..row0): 00 -> 1110111, 01 -> 1110110, 10 -> 0110110, 11 -> 0110110.
- Polarity inversion is applied after the registers. Reset and blank values are therefore the inactive pin level.

Decomposition:
- Shared package holds:
  - NUM_COLS and NUM_ROWS constants.
  - Irrigation status code constants for 00, 01, 10, 11.
  - FSM state encoding (BLANK=0, DRIVE=1).
- Sub-module irrigation_status_image:
  - Combinational.
  - Inputs col_idx and status; output is NUM_ROWS row bits.
  - Instantiates the five per-column irrigation status decoders and muxes them by col_idx.
- The controller keeps only the FSM, counters, status latch and output registers.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2 unless stated):
1. Reset for 3 cycles, then enable=1 and status=00.
   - cols=00000 in cycles 0-1.
   - cols=00001 in cycles 2-5, then 00010 from cycle 8.
   - frame_done high only in cycle 29; period is 30 cycles.
2. status=10, run to column 3.
   - While cols=01000, rows=0110110.
   - Switch status to 00 mid-frame: rows in column 3 stay 0110110 until the next frame, then read 1110111.
3. Deassert enable during column 2 DRIVE.
   - Next cycle: cols=00000, rows=0000000, and they stay there.
   - Re-enable: cols=00001 exactly 2 cycles later, with status re-sampled.
4. Assert reset during column 4 DRIVE with enable=1.
   - Next cycle: all outputs inactive and status_latched=00.
   - After release: column 0 goes active after 2 cycles.
5. COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=1, status=01.
   - Reset and blank drive cols=11111, rows=1111111.
   - Column 3 drive shows cols=10111, rows=0001001.
6. SCAN_DIV=1, BLANK_CYCLES=1.
   - Each column is active for exactly 1 cycle with 1 blank cycle between; col_idx wraps 4 -> 0.
   - frame_done pulses every 10 cycles.
